// File: rtl/video_composite_timing_pkg.sv
// Shared NTSC composite video timing constants and line classification,
// used by the timing generator and downstream pixel-fetch logic.
package video_composite_timing_pkg;

   localparam int unsigned NTSC_H_TOTAL        = 1588;
   localparam int unsigned NTSC_HSYNC_W        = 117;
   localparam int unsigned NTSC_EQ_W           = 59;
   localparam int unsigned NTSC_BURST_START    = 134;
   localparam int unsigned NTSC_BURST_W        = 63;
   localparam int unsigned NTSC_ACTIVE_START   = 238;
   localparam int unsigned NTSC_ACTIVE_W       = 1280;
   localparam int unsigned NTSC_V_TOTAL        = 262;
   localparam int unsigned NTSC_V_ACTIVE_START = 21;
   localparam int unsigned NTSC_V_ACTIVE_H     = 240;

   localparam int unsigned H_COUNT_W = 11;
   localparam int unsigned V_COUNT_W = 9;

   // Lines 0..8 carry the vertical interval; burst is always suppressed there.
   localparam logic [V_COUNT_W-1:0] FIRST_BURST_LINE = 9'd9;

   typedef enum logic [1:0] {
      LINE_NORMAL,
      LINE_EQUALIZE,
      LINE_VSYNC
   } line_type_e;

   function automatic line_type_e line_type_of(input logic [V_COUNT_W-1:0] vc);
      line_type_e lt;
      lt = LINE_NORMAL;
      if (vc <= 9'd2 || (vc >= 9'd6 && vc <= 9'd8)) begin
         lt = LINE_EQUALIZE;
      end else if (vc <= 9'd5) begin
         lt = LINE_VSYNC;
      end
      return lt;
   endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster position counters with a line-end strobe.
module video_timing_counter
   import video_composite_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL = NTSC_H_TOTAL,
   parameter int unsigned V_TOTAL = NTSC_V_TOTAL
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [H_COUNT_W-1:0] hc,
   output logic [V_COUNT_W-1:0] vc,
   output logic                 line_end
);

   localparam logic [H_COUNT_W-1:0] H_LAST = H_COUNT_W'(H_TOTAL - 1);
   localparam logic [V_COUNT_W-1:0] V_LAST = V_COUNT_W'(V_TOTAL - 1);

   logic [H_COUNT_W-1:0] hc_q, hc_d;
   logic [V_COUNT_W-1:0] vc_q, vc_d;
   logic                 line_end_d;

   always_comb begin
      line_end_d = (hc_q == H_LAST);
      hc_d       = line_end_d ? '0 : hc_q + 11'd1;
      vc_d       = vc_q;
      if (line_end_d) begin
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + 9'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   assign hc       = hc_q;
   assign vc       = vc_q;
   assign line_end = line_end_d;

endmodule

// File: rtl/video_composite_timing.sv
// NTSC 240p composite timing generator: sync with equalizing/serrated vsync,
// burst gate, active window and pixel coordinates, all registered one cycle behind.
module video_composite_timing
   import video_composite_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL        = NTSC_H_TOTAL,
   parameter int unsigned HSYNC_W        = NTSC_HSYNC_W,
   parameter int unsigned EQ_W           = NTSC_EQ_W,
   parameter int unsigned BURST_START    = NTSC_BURST_START,
   parameter int unsigned BURST_W        = NTSC_BURST_W,
   parameter int unsigned ACTIVE_START   = NTSC_ACTIVE_START,
   parameter int unsigned ACTIVE_W       = NTSC_ACTIVE_W,
   parameter int unsigned V_TOTAL        = NTSC_V_TOTAL,
   parameter int unsigned V_ACTIVE_START = NTSC_V_ACTIVE_START,
   parameter int unsigned V_ACTIVE_H     = NTSC_V_ACTIVE_H
) (
   input  logic        clk,
   input  logic        rst,
   output logic        sync_n,
   output logic        color_burst,
   output logic        active,
   output logic [10:0] h_count,
   output logic [8:0]  v_count,
   output logic        vblank,
   output logic        frame_start
);

   if (BURST_START + BURST_W > ACTIVE_START) begin : g_chk_burst
      $error("burst gate overlaps active window");
   end
   if (ACTIVE_START + ACTIVE_W > H_TOTAL) begin : g_chk_active
      $error("active window exceeds line length");
   end
   if (V_ACTIVE_START < 9) begin : g_chk_vstart
      $error("active lines overlap vertical interval");
   end
   if (V_ACTIVE_START + V_ACTIVE_H > V_TOTAL) begin : g_chk_vend
      $error("active lines exceed field length");
   end
   if (H_TOTAL > 2047 || V_TOTAL > 511) begin : g_chk_width
      $error("timing totals exceed counter width");
   end

   localparam logic [10:0] H_HALF      = 11'(H_TOTAL / 2);
   localparam logic [10:0] HS_END      = 11'(HSYNC_W);
   localparam logic [10:0] EQ_END      = 11'(EQ_W);
   localparam logic [10:0] EQ2_END     = 11'(H_TOTAL / 2 + EQ_W);
   localparam logic [10:0] SERR1_START = 11'(H_TOTAL / 2 - HSYNC_W);
   localparam logic [10:0] SERR2_START = 11'(H_TOTAL - HSYNC_W);
   localparam logic [10:0] BURST_LO    = 11'(BURST_START);
   localparam logic [10:0] BURST_HI    = 11'(BURST_START + BURST_W);
   localparam logic [10:0] ACT_LO      = 11'(ACTIVE_START);
   localparam logic [10:0] ACT_HI      = 11'(ACTIVE_START + ACTIVE_W);
   localparam logic [8:0]  VA_LO       = 9'(V_ACTIVE_START);
   localparam logic [8:0]  VA_HI       = 9'(V_ACTIVE_START + V_ACTIVE_H);

   logic [10:0] hc;
   logic [8:0]  vc;
   logic        line_end_unused;

   video_timing_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .hc       (hc),
      .vc       (vc),
      .line_end (line_end_unused)
   );

   line_type_e  line_type;
   logic        v_in_active;
   logic        sync_n_q, sync_n_d;
   logic        color_burst_q, color_burst_d;
   logic        active_q, active_d;
   logic        vblank_q, vblank_d;
   logic        frame_start_q, frame_start_d;
   logic [10:0] h_count_q, h_count_d;
   logic [8:0]  v_count_q, v_count_d;

   always_comb begin
      line_type   = line_type_of(vc);
      v_in_active = (vc >= VA_LO) && (vc < VA_HI);
      sync_n_d    = 1'b1;

      unique case (line_type)
         LINE_EQUALIZE: sync_n_d = !((hc < EQ_END) || (hc >= H_HALF && hc < EQ2_END));
         // Serrated vsync: sync is mostly low, released just before each half-line.
         LINE_VSYNC:    sync_n_d = (hc >= SERR1_START && hc < H_HALF) || (hc >= SERR2_START);
         default:       sync_n_d = !(hc < HS_END);
      endcase

      color_burst_d = (hc >= BURST_LO) && (hc < BURST_HI) && (vc >= FIRST_BURST_LINE);
      active_d      = (hc >= ACT_LO) && (hc < ACT_HI) && v_in_active;
      vblank_d      = !v_in_active;
      frame_start_d = (hc == '0) && (vc == '0);
      h_count_d     = hc;
      v_count_d     = vc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_n_q      <= 1'b1;
         color_burst_q <= 1'b0;
         active_q      <= 1'b0;
         vblank_q      <= 1'b1;
         frame_start_q <= 1'b0;
         h_count_q     <= '0;
         v_count_q     <= '0;
      end else begin
         sync_n_q      <= sync_n_d;
         color_burst_q <= color_burst_d;
         active_q      <= active_d;
         vblank_q      <= vblank_d;
         frame_start_q <= frame_start_d;
         h_count_q     <= h_count_d;
         v_count_q     <= v_count_d;
      end
   end

   assign sync_n      = sync_n_q;
   assign color_burst = color_burst_q;
   assign active      = active_q;
   assign vblank      = vblank_q;
   assign frame_start = frame_start_q;
   assign h_count     = h_count_q;
   assign v_count     = v_count_q;

endmodule

// File: tb/tb_video_composite_timing.sv
// Bench for video_composite_timing: NTSC-default instance plus a scaled-down
// instance for whole-field behaviour, both checked against a position model.
module tb_video_composite_timing;

   typedef struct packed {
      int ht; int hs; int eq; int bs; int bw;
      int as; int aw; int vt; int vas; int vah;
   } tp_t;

   typedef struct packed {
      logic        sync_n;
      logic        burst;
      logic        active;
      logic        vblank;
      logic        fs;
      logic [10:0] h;
      logic [8:0]  v;
   } out_t;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic rst_b = 1'b1;
   logic rst_s = 1'b1;

   logic        b_sync_n, b_burst, b_active, b_vblank, b_fs;
   logic [10:0] b_h;
   logic [8:0]  b_v;
   logic        s_sync_n, s_burst, s_active, s_vblank, s_fs;
   logic [10:0] s_h;
   logic [8:0]  s_v;

   video_composite_timing u_big (
      .clk         (clk),
      .rst         (rst_b),
      .sync_n      (b_sync_n),
      .color_burst (b_burst),
      .active      (b_active),
      .h_count     (b_h),
      .v_count     (b_v),
      .vblank      (b_vblank),
      .frame_start (b_fs)
   );

   video_composite_timing #(
      .H_TOTAL        (100),
      .HSYNC_W        (8),
      .EQ_W           (4),
      .BURST_START    (10),
      .BURST_W        (5),
      .ACTIVE_START   (20),
      .ACTIVE_W       (70),
      .V_TOTAL        (30),
      .V_ACTIVE_START (10),
      .V_ACTIVE_H     (18)
   ) u_small (
      .clk         (clk),
      .rst         (rst_s),
      .sync_n      (s_sync_n),
      .color_burst (s_burst),
      .active      (s_active),
      .h_count     (s_h),
      .v_count     (s_v),
      .vblank      (s_vblank),
      .frame_start (s_fs)
   );

   tp_t pb = '{1588, 117, 59, 134, 63, 238, 1280, 262, 21, 240};
   tp_t ps = '{100, 8, 4, 10, 5, 20, 70, 30, 10, 18};

   int checks = 0;
   int errors = 0;

   // Expected outputs n cycles after reset release (n < 0: still in reset).
   function automatic out_t model(input tp_t p, input int n);
      out_t o;
      int pos, h, v, half;
      o = '{sync_n: 1'b1, burst: 1'b0, active: 1'b0, vblank: 1'b1, fs: 1'b0, h: 11'd0, v: 9'd0};
      if (n >= 0) begin
         pos  = n % (p.ht * p.vt);
         h    = pos % p.ht;
         v    = pos / p.ht;
         half = p.ht / 2;
         if (v <= 2 || (v >= 6 && v <= 8))
            o.sync_n = !((h < p.eq) || (h >= half && h < half + p.eq));
         else if (v <= 5)
            o.sync_n = (h >= half - p.hs && h < half) || (h >= p.ht - p.hs);
         else
            o.sync_n = (h >= p.hs);
         o.burst  = (h >= p.bs) && (h < p.bs + p.bw) && (v >= 9);
         o.vblank = !(v >= p.vas && v < p.vas + p.vah);
         o.active = !o.vblank && (h >= p.as) && (h < p.as + p.aw);
         o.fs     = (h == 0) && (v == 0);
         o.h      = 11'(h);
         o.v      = 9'(v);
      end
      return o;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int nb = -1, ns = -1, cyc = 0;
   bit phase1 = 1'b1;
   out_t eb, es, ab, as_o;
   logic prev_bsync = 1'b1;

   int s30_low = 0, s30_low_last = -1;
   int s30_burst = 0, s30_burst_first = -1, s30_burst_last = -1;
   int s30_act = 0, s30_act_first = -1, s30_act_last = -1;
   int l1_low = 0, l1_burst = 0, l4_high = 0;
   int l1_falls[$];
   int l4_rises[$];
   int vb20 = -1, vb21 = -1, act_early = 0, fs_phase1 = 0;
   int s_last_fs = -1, s_intervals = 0;
   bit s_rst_seen = 1'b0;
   int svb27 = -1, svb28 = -1, s_act_late = 0;

   always @(posedge clk) begin
      nb = rst_b ? -1 : nb + 1;
      ns = rst_s ? -1 : ns + 1;
      if (rst_s) s_rst_seen = 1'b1;
      eb = model(pb, nb);
      es = model(ps, ns);
      #1;
      cyc++;
      ab   = '{b_sync_n, b_burst, b_active, b_vblank, b_fs, b_h, b_v};
      as_o = '{s_sync_n, s_burst, s_active, s_vblank, s_fs, s_h, s_v};
      checks++;
      if (ab !== eb) begin
         errors++;
         $display("FAIL big cyc=%0d got sync_n=%b burst=%b act=%b vbl=%b fs=%b h=%0d v=%0d expected sync_n=%b burst=%b act=%b vbl=%b fs=%b h=%0d v=%0d",
                  cyc, ab.sync_n, ab.burst, ab.active, ab.vblank, ab.fs, ab.h, ab.v,
                  eb.sync_n, eb.burst, eb.active, eb.vblank, eb.fs, eb.h, eb.v);
      end
      checks++;
      if (as_o !== es) begin
         errors++;
         $display("FAIL small cyc=%0d got sync_n=%b burst=%b act=%b vbl=%b fs=%b h=%0d v=%0d expected sync_n=%b burst=%b act=%b vbl=%b fs=%b h=%0d v=%0d",
                  cyc, as_o.sync_n, as_o.burst, as_o.active, as_o.vblank, as_o.fs, as_o.h, as_o.v,
                  es.sync_n, es.burst, es.active, es.vblank, es.fs, es.h, es.v);
      end

      if (phase1 && nb >= 0) begin
         if (b_fs) fs_phase1++;
         if (b_v <= 9'd20 && b_active) act_early++;
         if (b_v == 9'd20 && b_h == 11'd0) vb20 = int'(b_vblank);
         if (b_v == 9'd21 && b_h == 11'd0) vb21 = int'(b_vblank);
         if (b_v == 9'd30) begin
            if (!b_sync_n) begin s30_low++; s30_low_last = int'(b_h); end
            if (b_burst) begin
               s30_burst++;
               if (s30_burst_first < 0) s30_burst_first = int'(b_h);
               s30_burst_last = int'(b_h);
            end
            if (b_active) begin
               s30_act++;
               if (s30_act_first < 0) s30_act_first = int'(b_h);
               s30_act_last = int'(b_h);
            end
         end
         if (b_v == 9'd1) begin
            if (!b_sync_n) l1_low++;
            if (b_burst) l1_burst++;
            if (prev_bsync && !b_sync_n) l1_falls.push_back(int'(b_h));
         end
         if (b_v == 9'd4) begin
            if (b_sync_n) l4_high++;
            if (!prev_bsync && b_sync_n) l4_rises.push_back(int'(b_h));
         end
      end
      prev_bsync = b_sync_n;

      if (ns >= 0) begin
         if (s_v == 9'd27 && s_h == 11'd0) svb27 = int'(s_vblank);
         if (s_v == 9'd28 && s_h == 11'd0) svb28 = int'(s_vblank);
         if (s_v >= 9'd28 && s_active) s_act_late++;
         if (s_fs) begin
            if (s_last_fs >= 0 && !s_rst_seen) begin
               s_intervals++;
               checks++;
               if (cyc - s_last_fs != 3000) begin
                  errors++;
                  $display("FAIL small_frame_period: got %0d expected 3000", cyc - s_last_fs);
               end
            end
            s_last_fs  = cyc;
            s_rst_seen = 1'b0;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_b = 1'b0;
      rst_s = 1'b0;
      fork
         begin
            repeat (31 * 1588 + 500) @(negedge clk);
            phase1 = 1'b0;
            rst_b  = 1'b1;
            @(negedge clk);
            rst_b  = 1'b0;
            repeat (3 * 1588 + 10) @(negedge clk);
         end
         begin
            repeat (2 * 3000 + 50) @(negedge clk);
            for (int k = 0; k < 10; k++) begin
               repeat ($urandom_range(1, 4000)) @(negedge clk);
               rst_s = 1'b1;
               repeat ($urandom_range(1, 3)) @(negedge clk);
               rst_s = 1'b0;
            end
         end
      join

      chk("line30_sync_low_count", s30_low, 117);
      chk("line30_sync_low_last", s30_low_last, 116);
      chk("line30_burst_count", s30_burst, 63);
      chk("line30_burst_first", s30_burst_first, 134);
      chk("line30_burst_last", s30_burst_last, 196);
      chk("line30_active_count", s30_act, 1280);
      chk("line30_active_first", s30_act_first, 238);
      chk("line30_active_last", s30_act_last, 1517);
      chk("line1_low_count", l1_low, 118);
      chk("line1_burst_count", l1_burst, 0);
      chk("line1_fall_count", l1_falls.size(), 2);
      if (l1_falls.size() == 2) begin
         chk("line1_fall0", l1_falls[0], 0);
         chk("line1_fall1", l1_falls[1], 794);
      end
      chk("line4_high_count", l4_high, 234);
      chk("line4_rise_count", l4_rises.size(), 2);
      if (l4_rises.size() == 2) begin
         chk("line4_rise0", l4_rises[0], 677);
         chk("line4_rise1", l4_rises[1], 1471);
      end
      chk("vblank_line20", vb20, 1);
      chk("vblank_line21", vb21, 0);
      chk("active_lines_0_20", act_early, 0);
      chk("frame_start_once", fs_phase1, 1);
      chk("small_vblank_line27", svb27, 0);
      chk("small_vblank_line28", svb28, 1);
      chk("small_active_after_field", s_act_late, 0);
      if (s_intervals < 1) begin
         errors++;
         $display("FAIL small_frame_period_seen: got %0d expected at least 1", s_intervals);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
